boot_loader: RTL and testbench

- Boot-time sequencer that sits directly downstream of the program ROM. After reset and a start pulse, it walks the ROM address space, reads each instruction word and writes it into main RAM over a request/acknowledge handshake.
- Holds the CPU core in hold until the image copy completes, then releases it and leaves the shared data bus free.
- Owns the ROM "boot" enable: the ROM drives the data bus only while the loader is fetching.

---
 rtl/boot_loader_pkg.sv | 21 ++
 rtl/boot_loader.sv | 108 ++++++++++
 tb/tb_boot_loader.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: default bus widths, the
// sequencer state encoding and a helper that sizes the word counter.
package boot_loader_pkg;

  localparam int ADDR_SIZE = 8;
  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    BOOT_IDLE  = 2'd0,
    BOOT_FETCH = 2'd1,
    BOOT_WRITE = 2'd2,
    BOOT_DONE  = 2'd3
  } boot_state_e;

  // The counter only has to reach BOOT_WORDS-1; one spare bit keeps the
  // width non-zero when a single word is copied.
  function automatic int cntWidth(input int words);
    return $clog2(words) + 1;
  endfunction

endpackage

// File: rtl/boot_loader.sv
// Boot-time copy engine: walks the program ROM, writes every word into main
// RAM over a req/ack handshake, and keeps the CPU in hold until the image
// has been copied. The ROM is only allowed onto the data bus during FETCH.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int ADDR_W     = ADDR_SIZE,
  parameter int WORD_W     = WORD_SIZE,
  parameter int BOOT_WORDS = 4,
  parameter int ADDR_STEP  = 2,
  parameter int ROM_BASE   = 0,
  parameter int RAM_BASE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              boot,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic              ram_req,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_wdata,
  input  logic              ram_ack,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold
);

  localparam int CNT_W = cntWidth(BOOT_WORDS);

  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BOOT_WORDS - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ROM_START = ADDR_W'(ROM_BASE);
  localparam logic [ADDR_W-1:0] RAM_START = ADDR_W'(RAM_BASE);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);

  boot_state_e       state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // State and datapath registers; reset wins over everything, including an
  // in-flight RAM acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT_IDLE;
      rom_addr_q <= ROM_START;
      ram_addr_q <= RAM_START;
      wdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      ram_addr_q <= ram_addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic: start only matters when idle or finished, the copy
  // ends on the word counter (addresses may legally wrap), and ROM data is
  // captured on the closing edge of the single FETCH cycle.
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    ram_addr_d = ram_addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    case (state_q)
      BOOT_IDLE, BOOT_DONE: begin
        if (start) begin
          state_d    = BOOT_FETCH;
          rom_addr_d = ROM_START;
          ram_addr_d = RAM_START;
          cnt_d      = '0;
        end
      end
      BOOT_FETCH: begin
        wdata_d = rom_data;
        state_d = BOOT_WRITE;
      end
      BOOT_WRITE: begin
        if (ram_ack) begin
          if (cnt_q == LAST_CNT) begin
            state_d = BOOT_DONE;
          end else begin
            rom_addr_d = rom_addr_q + STEP;
            ram_addr_d = ram_addr_q + STEP;
            cnt_d      = cnt_q + CNT_ONE;
            state_d    = BOOT_FETCH;
          end
        end
      end
      default: state_d = BOOT_IDLE;
    endcase
  end

  assign boot      = (state_q == BOOT_FETCH);
  assign ram_req   = (state_q == BOOT_WRITE);
  assign busy      = (state_q == BOOT_FETCH) || (state_q == BOOT_WRITE);
  assign done      = (state_q == BOOT_DONE);
  assign cpu_hold  = (state_q != BOOT_DONE);
  assign rom_addr  = rom_addr_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: a behavioural ROM/RAM model computes which words
// must land where and how many edges a copy takes, and the DUT is compared
// against it under tied, stalled and random acknowledges, restart, reset
// mid-copy and address wrap-around.
module tb_boot_loader;

  localparam int AW   = 8;
  localparam int WW   = 16;
  localparam int NW   = 4;
  localparam int STEP = 2;
  localparam int AWW  = 3;
  localparam int NWW  = 2;
  localparam int ROMW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, ramAck;
  logic          boot, ramReq, busy, done, cpuHold;
  logic [AW-1:0] romAddr, ramAddr;
  logic [WW-1:0] romData, ramWdata;

  logic           startW, ackW;
  logic           bootW, ramReqW, busyW, doneW, cpuHoldW;
  logic [AWW-1:0] romAddrW, ramAddrW;
  logic [WW-1:0]  romDataW, ramWdataW;

  logic [WW-1:0]  romMem  [256];
  logic [WW-1:0]  romMemW [8];

  logic [AW-1:0]  wrAddrQ[$];
  logic [WW-1:0]  wrDataQ[$];
  logic [AWW-1:0] wrAddrWQ[$];
  logic [WW-1:0]  wrDataWQ[$];
  logic [AWW-1:0] romRdWQ[$];

  int total = 0;
  int bad   = 0;

  assign romData  = boot  ? romMem[romAddr]   : 16'hDEAD;
  assign romDataW = bootW ? romMemW[romAddrW] : 16'hDEAD;

  boot_loader #(.ADDR_W(AW), .WORD_W(WW), .BOOT_WORDS(NW), .ADDR_STEP(STEP),
                .ROM_BASE(0), .RAM_BASE(0)) dut (
    .clk(clk), .rst(rst), .start(start), .boot(boot), .rom_addr(romAddr),
    .rom_data(romData), .ram_req(ramReq), .ram_addr(ramAddr),
    .ram_wdata(ramWdata), .ram_ack(ramAck), .busy(busy), .done(done),
    .cpu_hold(cpuHold));

  boot_loader #(.ADDR_W(AWW), .WORD_W(WW), .BOOT_WORDS(NWW), .ADDR_STEP(STEP),
                .ROM_BASE(ROMW), .RAM_BASE(0)) dutWrap (
    .clk(clk), .rst(rst), .start(startW), .boot(bootW), .rom_addr(romAddrW),
    .rom_data(romDataW), .ram_req(ramReqW), .ram_addr(ramAddrW),
    .ram_wdata(ramWdataW), .ram_ack(ackW), .busy(busyW), .done(doneW),
    .cpu_hold(cpuHoldW));

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // RAM side of the model: log every accepted write and every wrap-instance
  // ROM fetch, and require that ROM and RAM never share a cycle.
  always @(posedge clk) begin
    if (ramReq && ramAck) begin
      wrAddrQ.push_back(ramAddr);
      wrDataQ.push_back(ramWdata);
    end
    if (ramReqW && ackW) begin
      wrAddrWQ.push_back(ramAddrW);
      wrDataWQ.push_back(ramWdataW);
    end
    if (bootW) romRdWQ.push_back(romAddrW);
    if (!rst) checkOutput("exclusive", 32'(boot & ramReq), 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full copy started from IDLE or DONE. Expected edge count follows
  // from the rules: two edges per word, one for the start edge, plus one per
  // cycle spent in WRITE without acknowledge.
  task automatic applyStimulus(input string tag, input int stallWord,
                               input int stallCycles, input bit randomAck,
                               input bit pokeStart);
    int            edges;
    int            lowCycles;
    int            stallLeft;
    logic [AW-1:0] a;
    wrAddrQ.delete();
    wrDataQ.delete();
    stallLeft = stallCycles;
    lowCycles = 0;
    ramAck = 1'b1;
    start  = 1'b1;
    step();
    edges = 1;
    start = 1'b0;
    checkOutput({tag, "_fetchAfterStart"}, 32'(boot), 32'd1);
    checkOutput({tag, "_doneCleared"}, 32'(done), 32'd0);
    checkOutput({tag, "_holdRaised"}, 32'(cpuHold), 32'd1);
    for (int i = 0; i < 200 && !done; i++) begin
      if (ramReq && wrAddrQ.size() == stallWord && stallLeft > 0) begin
        ramAck = 1'b0;
        stallLeft--;
        lowCycles++;
        a = AW'(STEP * stallWord);
        checkOutput({tag, "_stallAddr"}, 32'(ramAddr), 32'(a));
        checkOutput({tag, "_stallData"}, 32'(ramWdata), 32'(romMem[a]));
        checkOutput({tag, "_stallBoot"}, 32'(boot), 32'd0);
      end else if (randomAck) begin
        ramAck = 1'($urandom_range(0, 1));
        if (ramReq && !ramAck) lowCycles++;
      end else begin
        ramAck = 1'b1;
      end
      start = pokeStart && busy && ($urandom_range(0, 1) == 1);
      step();
      edges++;
    end
    start  = 1'b0;
    ramAck = 1'b0;
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_holdReleased"}, 32'(cpuHold), 32'd0);
    checkOutput({tag, "_idleBus"}, 32'(busy), 32'd0);
    checkOutput({tag, "_edges"}, 32'(edges), 32'(2 * NW + 1 + lowCycles));
    checkOutput({tag, "_writeCount"}, 32'(wrAddrQ.size()), 32'(NW));
    for (int k = 0; k < NW && k < wrAddrQ.size(); k++) begin
      a = AW'(STEP * k);
      checkOutput({tag, "_wrAddr"}, 32'(wrAddrQ[k]), 32'(a));
      checkOutput({tag, "_wrData"}, 32'(wrDataQ[k]), 32'(romMem[a]));
    end
  endtask

  task automatic fillRom();
    for (int i = 0; i < 256; i++) romMem[i] = 16'($urandom);
    for (int i = 0; i < 8; i++) romMemW[i] = 16'($urandom);
  endtask

  // Directed sequence: reset, basic copy, backpressure, random ack with
  // ignored starts, mid-copy reset, then the wrapping instance.
  initial begin
    int            edgesW;
    logic [AW-1:0] a;
    rst = 1'b1; start = 1'b0; ramAck = 1'b0; startW = 1'b0; ackW = 1'b0;
    fillRom();
    repeat (2) step();
    rst = 1'b0;
    checkOutput("rst_boot", 32'(boot), 32'd0);
    checkOutput("rst_req", 32'(ramReq), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_hold", 32'(cpuHold), 32'd1);
    checkOutput("rst_romAddr", 32'(romAddr), 32'd0);
    checkOutput("rst_ramAddr", 32'(ramAddr), 32'd0);
    checkOutput("rst_wdata", 32'(ramWdata), 32'd0);
    repeat (3) step();
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_hold", 32'(cpuHold), 32'd1);

    romMem[0] = 16'h1105; romMem[2] = 16'h1212;
    romMem[4] = 16'h21FE; romMem[6] = 16'h3001;
    applyStimulus("basic", -1, 0, 1'b0, 1'b0);
    applyStimulus("stall", 1, 3, 1'b0, 1'b0);
    fillRom();
    applyStimulus("random", -1, 0, 1'b1, 1'b1);

    wrAddrQ.delete();
    wrDataQ.delete();
    start = 1'b1;
    ramAck = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ramReq && wrAddrQ.size() == 2) break;
      ramAck = 1'b1;
      step();
    end
    checkOutput("mid_reachedWrite2", 32'(ramReq), 32'd1);
    ramAck = 1'b0;
    rst = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    checkOutput("mid_boot", 32'(boot), 32'd0);
    checkOutput("mid_req", 32'(ramReq), 32'd0);
    checkOutput("mid_busy", 32'(busy), 32'd0);
    checkOutput("mid_done", 32'(done), 32'd0);
    checkOutput("mid_hold", 32'(cpuHold), 32'd1);
    checkOutput("mid_romAddr", 32'(romAddr), 32'd0);
    checkOutput("mid_ramAddr", 32'(ramAddr), 32'd0);
    checkOutput("mid_wdata", 32'(ramWdata), 32'd0);
    repeat (3) step();
    checkOutput("mid_staysIdle", 32'(busy), 32'd0);
    applyStimulus("recopy", -1, 0, 1'b0, 1'b0);

    wrAddrWQ.delete();
    wrDataWQ.delete();
    romRdWQ.delete();
    ackW = 1'b1;
    startW = 1'b1;
    step();
    startW = 1'b0;
    edgesW = 1;
    for (int i = 0; i < 50 && !doneW; i++) begin
      step();
      edgesW++;
    end
    checkOutput("wrap_done", 32'(doneW), 32'd1);
    checkOutput("wrap_hold", 32'(cpuHoldW), 32'd0);
    checkOutput("wrap_busy", 32'(busyW), 32'd0);
    checkOutput("wrap_edges", 32'(edgesW), 32'(2 * NWW + 1));
    checkOutput("wrap_reads", 32'(romRdWQ.size()), 32'(NWW));
    checkOutput("wrap_writes", 32'(wrAddrWQ.size()), 32'(NWW));
    for (int k = 0; k < NWW && k < wrAddrWQ.size() && k < romRdWQ.size(); k++) begin
      a = AW'((ROMW + STEP * k) % 8);
      checkOutput("wrap_romAddr", 32'(romRdWQ[k]), 32'(a));
      checkOutput("wrap_ramAddr", 32'(wrAddrWQ[k]), 32'((STEP * k) % 8));
      checkOutput("wrap_data", 32'(wrDataWQ[k]), 32'(romMemW[a[AWW-1:0]]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
